// File: rtl/data_memory_arbiter.sv
// Two-master arbiter for the single-port data memory: burst-limited round-robin grant,
// combinational memory port mux, and a fixed-latency read-return pipe tagged by master id.
module data_memory_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int MAX_BURST    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_debugaccess,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic                    last_owner_q, last_owner_d;
  logic [READ_LATENCY-1:0] rd_vld_q;
  logic [READ_LATENCY-1:0] rd_id_q;

  logic req0, req1;
  logic gnt_vld, gnt_id;
  logic gnt_read, gnt_write;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Owner keeps the grant until its burst is spent and the other side is waiting.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0 && ((burst_cnt_q < MAX_CNT) || !req1)) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req1) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && ((burst_cnt_q < MAX_CNT) || !req0)) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end else if (req0) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_owner_q;
        end else if (req0) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req1) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
    endcase
    if (!reset_n) gnt_vld = 1'b0;
  end

  always_comb begin
    state_d      = IDLE;
    burst_cnt_d  = '0;
    last_owner_d = last_owner_q;
    if (gnt_vld) begin
      state_d      = gnt_id ? OWN1 : OWN0;
      last_owner_d = gnt_id;
      if (state_q == state_d)
        burst_cnt_d = (burst_cnt_q < MAX_CNT) ? burst_cnt_q + 1'b1 : MAX_CNT;
      else
        burst_cnt_d = CNT_W'(1);
    end
  end

  assign gnt_read  = gnt_id ? m1_read  : m0_read;
  assign gnt_write = gnt_id ? m1_write : m0_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b1;
      rd_vld_q     <= '0;
      rd_id_q      <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rd_vld_q[0]  <= gnt_vld & gnt_read;
      rd_id_q[0]   <= gnt_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_id_q[i]  <= rd_id_q[i-1];
      end
    end
  end

  // Waitrequest is only raised against a master that is asking and losing, or in reset.
  assign m0_waitrequest   = ~reset_n | (req0 & ~(gnt_vld & ~gnt_id));
  assign m1_waitrequest   = ~reset_n | (req1 & ~(gnt_vld &  gnt_id));
  assign m0_readdatavalid = rd_vld_q[READ_LATENCY-1] & ~rd_id_q[READ_LATENCY-1];
  assign m1_readdatavalid = rd_vld_q[READ_LATENCY-1] &  rd_id_q[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_address      = gnt_id ? m1_address    : m0_address;
  assign mem_byteenable   = gnt_id ? m1_byteenable : m0_byteenable;
  assign mem_writedata    = gnt_id ? m1_writedata  : m0_writedata;
  assign mem_chipselect   = gnt_vld;
  assign mem_write        = gnt_vld & gnt_write;
  assign mem_debugaccess  = mem_write;
  assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: scenario tasks with inline checks plus a read-return
// scoreboard fed by the scenarios and drained by a monitor on mN_readdatavalid.
module tb_data_memory_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_rdata = '0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  data_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_debugaccess(mem_debugaccess), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 | {18'd0, a};
  endfunction

  // Memory stand-in with one cycle of read latency; contents are a function of address.
  always @(posedge clk)
    if (mem_chipselect && !mem_write) mem_rdata <= rd_word(mem_address);

  always @(negedge clk) begin
    logic        v;
    logic [31:0] d;
    exp_t        e;
    for (int n = 0; n < 2; n++) begin
      v = (n == 1) ? m1_readdatavalid : m0_readdatavalid;
      d = (n == 1) ? m1_readdata : m0_readdata;
      if (v) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errs++;
          $display("FAIL rd_unexpected: m%0d_readdatavalid=1 with no read outstanding", n);
        end else begin
          e = sb_q.pop_front();
          if (e.id !== logic'(n) || e.data !== d) begin
            n_errs++;
            $display("FAIL rd_return: got m%0d data %h, required m%0d data %h", n, d, e.id, e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    m0_read = 1'b1; m0_address = 14'h0021;
    m1_write = 1'b1; m1_address = 14'h0042; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
    @(negedge clk); #1;
    n_checks++; if (m0_waitrequest !== 1'b1) begin n_errs++; $display("FAIL rst_wait0: got %b required 1", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_errs++; $display("FAIL rst_wait1: got %b required 1", m1_waitrequest); end
    n_checks++; if (mem_chipselect !== 1'b0) begin n_errs++; $display("FAIL rst_cs: got %b required 0", mem_chipselect); end
    n_checks++; if (mem_write !== 1'b0) begin n_errs++; $display("FAIL rst_wr: got %b required 0", mem_write); end
    n_checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_errs++; $display("FAIL rst_rdv: got %b%b required 00", m0_readdatavalid, m1_readdatavalid); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errs++; $display("FAIL tie_wait0: got %b required 0", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b1) begin n_errs++; $display("FAIL tie_wait1: got %b required 1", m1_waitrequest); end
    n_checks++; if (mem_address !== 14'h0021) begin n_errs++; $display("FAIL tie_addr: got %h required 0021", mem_address); end
    n_checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
      n_errs++; $display("FAIL tie_cs_wr: got %b%b required 10", mem_chipselect, mem_write); end
    sb_q.push_back('{1'b0, rd_word(14'h0021)});
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 14'h0010;
    #1;
    n_checks++; if (mem_address !== 14'h0010) begin n_errs++; $display("FAIL rd1_addr: got %h required 0010", mem_address); end
    n_checks++; if (mem_chipselect !== 1'b1) begin n_errs++; $display("FAIL rd1_cs: got %b required 1", mem_chipselect); end
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errs++; $display("FAIL rd1_wait0: got %b required 0", m0_waitrequest); end
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_errs++; $display("FAIL rd1_wait1_idle: got %b required 0", m1_waitrequest); end
    sb_q.push_back('{1'b0, rd_word(14'h0010)});
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (m0_readdatavalid !== 1'b1) begin n_errs++; $display("FAIL rd1_valid: got %b required 1", m0_readdatavalid); end
    n_checks++; if (m0_readdata !== rd_word(14'h0010)) begin n_errs++; $display("FAIL rd1_data: got %h required %h", m0_readdata, rd_word(14'h0010)); end
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_errs++; $display("FAIL rd1_m1valid: got %b required 0", m1_readdatavalid); end
  endtask

  task automatic test_round_robin();
    int          exp_g[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [13:0] a0 = 14'h0100;
    logic [13:0] a1 = 14'h0200;
    logic        g;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      m0_read = 1'b1; m1_read = 1'b1; m0_address = a0; m1_address = a1;
      #1;
      g = (exp_g[i] == 1);
      n_checks++; if (m0_waitrequest !== g) begin n_errs++; $display("FAIL rr_wait0[%0d]: got %b required %b", i, m0_waitrequest, g); end
      n_checks++; if (m1_waitrequest !== !g) begin n_errs++; $display("FAIL rr_wait1[%0d]: got %b required %b", i, m1_waitrequest, !g); end
      n_checks++; if (mem_address !== (g ? a1 : a0)) begin n_errs++; $display("FAIL rr_addr[%0d]: got %h required %h", i, mem_address, g ? a1 : a0); end
      sb_q.push_back('{g, rd_word(g ? a1 : a0)});
      if (g) a1 = a1 + 14'd1;
      else   a0 = a0 + 14'd1;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_write();
    @(negedge clk);
    m1_write = 1'b1; m1_address = 14'h3FFF; m1_byteenable = 4'b0011; m1_writedata = 32'hDEADBEEF;
    #1;
    n_checks++; if (mem_write !== 1'b1) begin n_errs++; $display("FAIL wr_write: got %b required 1", mem_write); end
    n_checks++; if (mem_debugaccess !== 1'b1) begin n_errs++; $display("FAIL wr_dbg: got %b required 1", mem_debugaccess); end
    n_checks++; if (mem_byteenable !== 4'b0011) begin n_errs++; $display("FAIL wr_be: got %b required 0011", mem_byteenable); end
    n_checks++; if (mem_address !== 14'h3FFF) begin n_errs++; $display("FAIL wr_addr: got %h required 3fff", mem_address); end
    n_checks++; if (mem_writedata !== 32'hDEADBEEF) begin n_errs++; $display("FAIL wr_data: got %h required deadbeef", mem_writedata); end
    n_checks++; if (mem_chipselect !== 1'b1) begin n_errs++; $display("FAIL wr_cs: got %b required 1", mem_chipselect); end
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_errs++; $display("FAIL wr_wait1: got %b required 0", m1_waitrequest); end
    n_checks++; if (mem_clken !== 1'b1) begin n_errs++; $display("FAIL wr_clken: got %b required 1", mem_clken); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_checks++; if (mem_chipselect !== 1'b0) begin n_errs++; $display("FAIL idle_cs: got %b required 0", mem_chipselect); end
    n_checks++; if (mem_write !== 1'b0 || mem_debugaccess !== 1'b0) begin
      n_errs++; $display("FAIL idle_wr: got %b%b required 00", mem_write, mem_debugaccess); end
    n_checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
      n_errs++; $display("FAIL idle_wait: got %b%b required 00", m0_waitrequest, m1_waitrequest); end
  endtask

  task automatic test_burst_handoff();
    int          r0[7]    = '{1, 1, 0, 1, 1, 1, 1};
    int          r1[7]    = '{0, 1, 1, 1, 1, 1, 1};
    int          exp_g[7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [13:0] a0 = 14'h0300;
    logic [13:0] a1 = 14'h0380;
    logic        g;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m0_read = (r0[i] == 1); m1_read = (r1[i] == 1); m0_address = a0; m1_address = a1;
      #1;
      g = (exp_g[i] == 1);
      n_checks++; if (m0_waitrequest !== (m0_read && g)) begin
        n_errs++; $display("FAIL ho_wait0[%0d]: got %b required %b", i, m0_waitrequest, m0_read && g); end
      n_checks++; if (m1_waitrequest !== (m1_read && !g)) begin
        n_errs++; $display("FAIL ho_wait1[%0d]: got %b required %b", i, m1_waitrequest, m1_read && !g); end
      n_checks++; if (mem_address !== (g ? a1 : a0)) begin
        n_errs++; $display("FAIL ho_addr[%0d]: got %h required %h", i, mem_address, g ? a1 : a0); end
      sb_q.push_back('{g, rd_word(g ? a1 : a0)});
      if (g) a1 = a1 + 14'd1;
      else   a0 = a0 + 14'd1;
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_drop();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 14'h0055;
    #1;
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_errs++; $display("FAIL drop_accept: got %b required 0", m0_waitrequest); end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    clear_inputs();
    #1;
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errs++; $display("FAIL drop_valid_rst: got %b required 0", m0_readdatavalid); end
    @(negedge clk);
    #1;
    n_checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_errs++; $display("FAIL drop_valid_hold: got %b%b required 00", m0_readdatavalid, m1_readdatavalid); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_errs++; $display("FAIL drop_valid_after: got %b required 0", m0_readdatavalid); end
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (sb_q.size() != 0) begin
      n_errs++; $display("FAIL sb_drain: got %0d reads outstanding required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_burst_handoff();
    test_reset_drop();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
